// File: rtl/rowseg_pkg.sv
// Shared types and constants for the row band segmenter.
package rowseg_pkg;

   typedef enum logic {
      SEARCH  = 1'b0,
      IN_BAND = 1'b1
   } seg_state_t;

   // Band records use a fixed field width. Modules carry CW-bit coordinates
   // zero-extended into these fields, so CW must not exceed COORD_W.
   localparam int COORD_W = 16;

   typedef struct packed {
      logic [COORD_W-1:0] upper;
      logic [COORD_W-1:0] lower;
   } band_t;

   localparam logic [7:0] WHITE_PIX = 8'hFF;

endpackage

// File: rtl/row_band_segmenter_band_bank.sv
// band_bank: working band slots filled during a frame, plus a committed copy
// that is swapped in atomically at frame end and read through a registered port.
module band_bank
   import rowseg_pkg::*;
#(
   parameter int NBANDS = 4,
   parameter int IW     = 2,
   parameter int CNTW   = 3
) (
   input  logic            clock,
   input  logic            rst_n,
   input  logic            clear,
   input  logic            commit,
   input  band_t           commit_band,
   input  logic            swap,
   input  logic [IW-1:0]   rd_idx,
   output band_t           rd_band,
   output logic [CNTW-1:0] band_count,
   output logic            overflow
);

   band_t           wk_slot     [NBANDS];
   band_t           wk_slot_nxt [NBANDS];
   band_t           cm_slot     [NBANDS];
   logic [CNTW-1:0] wk_count;
   logic [CNTW-1:0] wk_count_nxt;
   logic            wk_ovf;
   logic            wk_ovf_nxt;
   band_t           rd_sel;

   // Working bank after this cycle's clear and commit; this is also the image
   // copied on swap, so a band closed on the last pixel is included.
   always_comb begin
      wk_slot_nxt  = wk_slot;
      wk_count_nxt = clear ? '0 : wk_count;
      wk_ovf_nxt   = clear ? 1'b0 : wk_ovf;
      if (commit) begin
         if (wk_count_nxt < CNTW'(NBANDS)) begin
            for (int i = 0; i < NBANDS; i++) begin
               if (CNTW'(i) == wk_count_nxt) wk_slot_nxt[i] = commit_band;
            end
            wk_count_nxt = wk_count_nxt + CNTW'(1);
         end else begin
            wk_ovf_nxt = 1'b1;
         end
      end
   end

   // Select the committed slot addressed by rd_idx.
   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < NBANDS; i++) begin
         if (IW'(i) == rd_idx) rd_sel = cm_slot[i];
      end
   end

   // Working/committed storage, swap at frame end, registered read port.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NBANDS; i++) begin
            wk_slot[i] <= '0;
            cm_slot[i] <= '0;
         end
         wk_count   <= '0;
         wk_ovf     <= 1'b0;
         band_count <= '0;
         overflow   <= 1'b0;
         rd_band    <= '0;
      end else begin
         wk_slot <= wk_slot_nxt;
         if (swap) begin
            cm_slot    <= wk_slot_nxt;
            band_count <= wk_count_nxt;
            overflow   <= wk_ovf_nxt;
            wk_count   <= '0;
            wk_ovf     <= 1'b0;
         end else begin
            wk_count <= wk_count_nxt;
            wk_ovf   <= wk_ovf_nxt;
         end
         rd_band <= (CNTW'(rd_idx) < band_count) ? rd_sel : '0;
      end
   end

endmodule

// File: rtl/row_band_segmenter.sv
// row_band_segmenter: finds horizontal bands of "ink" rows in a raster frame
// and publishes up to NBANDS (upper, lower) row pairs once per frame.
// Optional build macro ROWSEG_MINH_EN adds parameter MIN_H; bands shorter
// than MIN_H rows are dropped at commit.
//
// state   | meaning
// --------+------------------------------------------------------------
// SEARCH  | between bands; waiting for a row whose dark count > thresh
// IN_BAND | inside a band; upper recorded, waiting for a non-ink row
module row_band_segmenter
   import rowseg_pkg::*;
#(
   parameter int IMG_W  = 480,
   parameter int IMG_H  = 272,
   parameter int NBANDS = 4,
   parameter int CW     = 9
`ifdef ROWSEG_MINH_EN
   ,
   parameter int MIN_H  = 8
`endif
) (
   input  logic                                          clock,
   input  logic                                          rst_n,
   input  logic                                          pix_valid,
   input  logic                                          sof,
   input  logic [7:0]                                    pix_data,
   input  logic [CW-1:0]                                 thresh,
   input  logic [((NBANDS > 1) ? $clog2(NBANDS) : 1)-1:0] rd_idx,
   output logic [CW-1:0]                                 rd_upper,
   output logic [CW-1:0]                                 rd_lower,
   output logic [$clog2(NBANDS+1)-1:0]                   band_count,
   output logic                                          frame_done,
   output logic                                          overflow
);

   localparam int IW   = (NBANDS > 1) ? $clog2(NBANDS) : 1;
   localparam int CNTW = $clog2(NBANDS + 1);

   seg_state_t    state;
   seg_state_t    state_nxt;
   seg_state_t    eff_state;
   logic [CW-1:0] col;
   logic [CW-1:0] row;
   logic [CW-1:0] row_cnt;
   logic [CW-1:0] upper_q;
   logic [CW-1:0] upper_nxt;
   logic [CW-1:0] eff_col;
   logic [CW-1:0] eff_row;
   logic [CW-1:0] eff_cnt;
   logic [CW-1:0] cnt_sum;
   logic [CW-1:0] commit_lower;
   logic          dark;
   logic          row_end;
   logic          last_row;
   logic          frame_end;
   logic          ink;
   logic          commit_req;
   logic          commit_ok;
   band_t         commit_band;
   band_t         rd_band;
   logic          unused_rd_hi;
`ifdef ROWSEG_MINH_EN
   logic [CW-1:0] band_h;
`endif

   // Position of the current pixel; sof forces (0,0) and restarts the row count.
   always_comb begin
      eff_col   = sof ? '0 : col;
      eff_row   = sof ? '0 : row;
      eff_cnt   = sof ? '0 : row_cnt;
      eff_state = sof ? SEARCH : state;
      dark      = (pix_data != WHITE_PIX);
      cnt_sum   = (dark && (eff_cnt != '1)) ? eff_cnt + CW'(1) : eff_cnt;
      row_end   = pix_valid && (eff_col == CW'(IMG_W - 1));
      last_row  = (eff_row == CW'(IMG_H - 1));
      frame_end = row_end && last_row;
      ink       = (cnt_sum > thresh);
   end

   // Column/row counters and per-row dark count; stalled while pix_valid is low.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         col     <= '0;
         row     <= '0;
         row_cnt <= '0;
      end else if (pix_valid) begin
         if (row_end) begin
            col     <= '0;
            row     <= last_row ? '0 : eff_row + CW'(1);
            row_cnt <= '0;
         end else begin
            col     <= eff_col + CW'(1);
            row     <= eff_row;
            row_cnt <= cnt_sum;
         end
      end
   end

   // Band FSM: evaluated at each row end, always back in SEARCH after the last row.
   always_comb begin
      state_nxt    = state;
      upper_nxt    = upper_q;
      commit_req   = 1'b0;
      commit_lower = '0;
      if (pix_valid) begin
         state_nxt = eff_state;
         if (row_end) begin
            case (eff_state)
               SEARCH: begin
                  if (ink) begin
                     state_nxt = IN_BAND;
                     upper_nxt = eff_row;
                  end
               end
               IN_BAND: begin
                  if (!ink) begin
                     commit_req   = 1'b1;
                     commit_lower = eff_row - CW'(1);
                     state_nxt    = SEARCH;
                  end else if (last_row) begin
                     commit_req   = 1'b1;
                     commit_lower = eff_row;
                  end
               end
               default: state_nxt = SEARCH;
            endcase
            if (last_row) state_nxt = SEARCH;
         end
      end
   end

   // State, recorded band top, and the frame-end pulse.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state      <= SEARCH;
         upper_q    <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         upper_q    <= upper_nxt;
         frame_done <= frame_end;
      end
   end

   // Qualify a closed band before it reaches the bank.
   always_comb begin
`ifdef ROWSEG_MINH_EN
      band_h    = commit_lower - upper_q + CW'(1);
      commit_ok = commit_req && (band_h >= CW'(MIN_H));
`else
      commit_ok = commit_req;
`endif
   end

   assign commit_band  = '{upper: COORD_W'(upper_q), lower: COORD_W'(commit_lower)};
   assign rd_upper     = rd_band.upper[CW-1:0];
   assign rd_lower     = rd_band.lower[CW-1:0];
   assign unused_rd_hi = ^{rd_band.upper[COORD_W-1:CW], rd_band.lower[COORD_W-1:CW]};

   band_bank #(
      .NBANDS (NBANDS),
      .IW     (IW),
      .CNTW   (CNTW)
   ) u_bank (
      .clock       (clock),
      .rst_n       (rst_n),
      .clear       (pix_valid && sof),
      .commit      (commit_ok),
      .commit_band (commit_band),
      .swap        (frame_end),
      .rd_idx      (rd_idx),
      .rd_band     (rd_band),
      .band_count  (band_count),
      .overflow    (overflow)
   );

endmodule
